crack_match_tracker: RTL

//  Sits directly downstream of the hash Comparator in the MD5 cracker. Holds every

---
 rtl/crack_match_tracker.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/crack_match_tracker.sv
// In-order candidate tracker behind the MD5 hash comparator: latches the first matching word.
// Optional stall watchdog is enabled by defining CRACK_TRACKER_TIMEOUT_EN.
module crack_match_tracker #(
  parameter int CAND_W  = 64,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              cand_valid,
  input  logic [CAND_W-1:0] cand_word,
  output logic              cand_ready,
  input  logic              equal_valid,
  input  logic              hashes_equal,
  output logic              busy,
  output logic              found,
  output logic [CAND_W-1:0] found_word,
  output logic [CNT_W-1:0]  tested_count,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEARCH, FOUND, ERROR} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_next;
  logic [PTR_W:0]     count, count_next;
  logic [CAND_W-1:0]  found_word_next;
  logic [CNT_W-1:0]   tested_count_next;
  logic [CAND_W-1:0]  mem [DEPTH];
  logic [CAND_W-1:0]  head;
  logic               wr_en;
  logic               fifo_empty;
  logic               fifo_full;

`ifdef CRACK_TRACKER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall, stall_next;
  logic [STALL_W-1:0] stall_inc;
  assign stall_inc = stall + 1'b1;
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
  assign cand_ready = (state == SEARCH) && !fifo_full;
  assign head       = mem[rd_ptr];

  // Status flags are pure decodes of the state register, so they change only on clock edges.
  assign busy  = (state == SEARCH);
  assign found = (state == FOUND);
  assign err   = (state == ERROR);

  always_comb begin
    state_next        = state;
    rd_ptr_next       = rd_ptr;
    wr_ptr_next       = wr_ptr;
    count_next        = count;
    found_word_next   = found_word;
    tested_count_next = tested_count;
    wr_en             = 1'b0;
`ifdef CRACK_TRACKER_TIMEOUT_EN
    stall_next        = stall;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          state_next        = SEARCH;
          rd_ptr_next       = '0;
          wr_ptr_next       = '0;
          count_next        = '0;
          found_word_next   = '0;
          tested_count_next = '0;
`ifdef CRACK_TRACKER_TIMEOUT_EN
          stall_next        = '0;
`endif
        end
      end

      SEARCH: begin
        // A result with nothing queued is an underflow even if a push lands on the same edge.
        if (equal_valid && fifo_empty) begin
          state_next = ERROR;
        end else begin
          wr_en = cand_valid && cand_ready;
          if (wr_en) begin
            wr_ptr_next = wr_ptr + 1'b1;
          end
          if (equal_valid) begin
            rd_ptr_next = rd_ptr + 1'b1;
            if (tested_count != {CNT_W{1'b1}}) begin
              tested_count_next = tested_count + 1'b1;
            end
            if (hashes_equal) begin
              found_word_next = head;
              state_next      = FOUND;
            end
          end
          case ({wr_en, equal_valid})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
          endcase
`ifdef CRACK_TRACKER_TIMEOUT_EN
          if (equal_valid || fifo_empty) begin
            stall_next = '0;
          end else begin
            stall_next = stall_inc;
            if (stall_inc == STALL_W'(TIMEOUT)) begin
              state_next = ERROR;
            end
          end
`endif
        end
      end

      default: ;
    endcase

    // clear wins over every state transition, including a simultaneous start.
    if (clear) begin
      state_next        = IDLE;
      rd_ptr_next       = '0;
      wr_ptr_next       = '0;
      count_next        = '0;
      found_word_next   = '0;
      tested_count_next = '0;
      wr_en             = 1'b0;
`ifdef CRACK_TRACKER_TIMEOUT_EN
      stall_next        = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      found_word   <= '0;
      tested_count <= '0;
`ifdef CRACK_TRACKER_TIMEOUT_EN
      stall        <= '0;
`endif
    end else begin
      state        <= state_next;
      rd_ptr       <= rd_ptr_next;
      wr_ptr       <= wr_ptr_next;
      count        <= count_next;
      found_word   <= found_word_next;
      tested_count <= tested_count_next;
`ifdef CRACK_TRACKER_TIMEOUT_EN
      stall        <= stall_next;
`endif
    end
  end

  // Storage needs no reset: validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= cand_word;
    end
  end

endmodule
